score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper_if.sv | 30 +++
 rtl/score_keeper.sv | 143 ++++++++++++++
 tb/tb_score_keeper.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/score_keeper_if.sv
// Score keeper bus: scene/pipe position from the game controller,
// score/best/event outputs toward the display.
interface score_keeper_if;
  logic [1:0]  scene;
  logic [7:0]  front_pos;
  logic [11:0] score_bcd;
  logic [11:0] best_bcd;
  logic        score_evt;
  logic        new_best;

  // Controller side: drives scene and pipe position, observes score.
  modport master (
    output scene,
    output front_pos,
    input  score_bcd,
    input  best_bcd,
    input  score_evt,
    input  new_best
  );

  // Score keeper side.
  modport slave (
    input  scene,
    input  front_pos,
    output score_bcd,
    output best_bcd,
    output score_evt,
    output new_best
  );
endinterface

// File: rtl/score_keeper.sv
// Score keeper: counts pipe passes in BCD during a run, tracks the best
// score since reset and flags a new best while the game-over screen is up.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | splash / waiting for a run to start; last score still shown
// RUN   | run in progress, pipe passes counted
// OVER  | run finished, best updated, new_best flag valid
module score_keeper #(
  parameter int BIRD_COL    = 10,
  parameter int PASS_OFFSET = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  score_keeper_if.slave bus
);

  localparam logic [7:0] PASS_COL  = 8'(BIRD_COL - PASS_OFFSET);
  localparam logic [7:0] PASS_PREV = 8'(BIRD_COL - PASS_OFFSET + 1);

  localparam logic [1:0] SCENE_SPLASH = 2'd0;
  localparam logic [1:0] SCENE_PLAY   = 2'd1;
  localparam logic [1:0] SCENE_OVER   = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  prev_pos_q;
  logic [11:0] score_q, score_d;
  logic [11:0] best_q, best_d;
  logic        evt_q, evt_d;
  logic        new_best_q, new_best_d;

  logic        pass_evt;
  logic        score_sat;
  logic [11:0] score_inc;

  // Three-digit BCD increment; caller guards the 999 case.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [3:0] d0, d1, d2;
    d2 = v[11:8];
    d1 = v[7:4];
    d0 = v[3:0];
    if (d0 == 4'd9) begin
      d0 = 4'd0;
      if (d1 == 4'd9) begin
        d1 = 4'd0;
        d2 = d2 + 4'd1;
      end else begin
        d1 = d1 + 4'd1;
      end
    end else begin
      d0 = d0 + 4'd1;
    end
    return {d2, d1, d0};
  endfunction

  // A pass is a single downward step onto the pass column; holds and
  // upward rotation jumps cannot satisfy the prev_pos condition.
  assign pass_evt  = (state_q == RUN) && (bus.scene == SCENE_PLAY) &&
                     (bus.front_pos == PASS_COL) && (prev_pos_q == PASS_PREV);
  assign score_sat = (score_q == 12'h999);
  assign score_inc = bcd_inc(score_q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; reserved scene code holds every state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.scene == SCENE_PLAY)   state_d = RUN;
      RUN: begin
        if (bus.scene == SCENE_OVER)        state_d = OVER;
        else if (bus.scene == SCENE_SPLASH) state_d = IDLE;
      end
      OVER: if (bus.scene == SCENE_SPLASH) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    score_d    = score_q;
    best_d     = best_q;
    new_best_d = new_best_q;
    evt_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.scene == SCENE_PLAY) score_d = 12'h000;
      end
      RUN: begin
        // Game over wins over a coincident pass: the pre-event score is final.
        if (bus.scene == SCENE_OVER) begin
          if (score_q > best_q) begin
            best_d     = score_q;
            new_best_d = 1'b1;
          end
        end else if (pass_evt && !score_sat) begin
          score_d = score_inc;
          evt_d   = 1'b1;
        end
      end
      OVER: begin
        if (bus.scene == SCENE_SPLASH) new_best_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Output and pipe-position history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_pos_q <= 8'd0;
      score_q    <= 12'h000;
      best_q     <= 12'h000;
      evt_q      <= 1'b0;
      new_best_q <= 1'b0;
    end else begin
      prev_pos_q <= bus.front_pos;
      score_q    <= score_d;
      best_q     <= best_d;
      evt_q      <= evt_d;
      new_best_q <= new_best_d;
    end
  end

  assign bus.score_bcd = score_q;
  assign bus.best_bcd  = best_q;
  assign bus.score_evt = evt_q;
  assign bus.new_best  = new_best_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: a vector table for the basic flow plus
// hand-written sequences for best tracking, collision, reset and carry.
module tb_score_keeper;

  typedef struct {
    logic [1:0]  scene;
    logic [7:0]  pos;
    logic [11:0] score;
    logic [11:0] best;
    logic        evt;
    logic        nb;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_fail;
  vec_t tbl[$];

  score_keeper_if bus ();

  score_keeper #(.BIRD_COL(10), .PASS_OFFSET(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic void add(input logic [1:0] s, input logic [7:0] p,
                              input logic [11:0] sc, input logic [11:0] bs,
                              input logic ev, input logic nb);
    vec_t v;
    v.scene = s; v.pos = p; v.score = sc; v.best = bs; v.evt = ev; v.nb = nb;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input logic [11:0] sc, input logic [11:0] bs,
                         input logic ev, input logic nb);
    chk({name, ".score"},    bus.score_bcd, sc);
    chk({name, ".best"},     bus.best_bcd,  bs);
    chk({name, ".evt"},      12'(bus.score_evt), 12'(ev));
    chk({name, ".new_best"}, 12'(bus.new_best),  12'(nb));
  endtask

  task automatic step(input logic [1:0] s, input logic [7:0] p);
    @(negedge clk);
    bus.scene     = s;
    bus.front_pos = p;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.scene = 2'd0;
    bus.front_pos = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic enter_run(input logic [11:0] bs);
    step(2'd0, 8'd20);
    step(2'd1, 8'd20);
    chk_all("enter_run", 12'h000, bs, 1'b0, 1'b0);
  endtask

  // One downward step 4 -> 3 while playing; exp_n is the expected score count.
  task automatic do_pass(input string name, input int exp_n, input logic exp_evt,
                         input logic [11:0] bs);
    step(2'd1, 8'd4);
    chk({name, ".pre_evt"}, 12'(bus.score_evt), 12'd0);
    step(2'd1, 8'd3);
    chk({name, ".evt"},   12'(bus.score_evt), 12'(exp_evt));
    chk({name, ".score"}, bus.score_bcd, to_bcd(exp_n));
    chk({name, ".best"},  bus.best_bcd, bs);
  endtask

  initial begin
    n_vec = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.scene = 2'd0;
    bus.front_pos = 8'd0;
    #2;
    chk_all("reset", 12'h000, 12'h000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic count: ramp 10..0, each value held 3 cycles.
    add(2'd0, 8'd0, 12'h000, 12'h000, 1'b0, 1'b0);
    add(2'd1, 8'd10, 12'h000, 12'h000, 1'b0, 1'b0);
    for (int v = 10; v >= 0; v--)
      for (int k = 0; k < 3; k++)
        add(2'd1, 8'(v), (v <= 3) ? 12'h001 : 12'h000, 12'h000,
            (v == 3 && k == 0), 1'b0);
    // Rotation jumps never count.
    add(2'd1, 8'd1,  12'h001, 12'h000, 1'b0, 1'b0);
    add(2'd1, 8'd0,  12'h001, 12'h000, 1'b0, 1'b0);
    add(2'd1, 8'd50, 12'h001, 12'h000, 1'b0, 1'b0);
    add(2'd1, 8'd49, 12'h001, 12'h000, 1'b0, 1'b0);
    add(2'd1, 8'd60, 12'h001, 12'h000, 1'b0, 1'b0);
    add(2'd1, 8'd3,  12'h001, 12'h000, 1'b0, 1'b0);
    add(2'd1, 8'd3,  12'h001, 12'h000, 1'b0, 1'b0);
    // Reserved scene: a 4 -> 3 step is ignored.
    add(2'd3, 8'd4,  12'h001, 12'h000, 1'b0, 1'b0);
    add(2'd3, 8'd3,  12'h001, 12'h000, 1'b0, 1'b0);
    add(2'd1, 8'd2,  12'h001, 12'h000, 1'b0, 1'b0);
    // Game over, hold, then back to splash.
    add(2'd2, 8'd2,  12'h001, 12'h001, 1'b0, 1'b1);
    add(2'd2, 8'd2,  12'h001, 12'h001, 1'b0, 1'b1);
    add(2'd3, 8'd2,  12'h001, 12'h001, 1'b0, 1'b1);
    add(2'd0, 8'd5,  12'h001, 12'h001, 1'b0, 1'b0);
    add(2'd0, 8'd5,  12'h001, 12'h001, 1'b0, 1'b0);

    foreach (tbl[i]) begin
      step(tbl[i].scene, tbl[i].pos);
      chk_all($sformatf("vec%0d", i), tbl[i].score, tbl[i].best, tbl[i].evt, tbl[i].nb);
    end

    // Best tracking: 5 beats 1, equal 5 does not, 6 beats 5.
    enter_run(12'h001);
    for (int i = 1; i <= 5; i++) do_pass("run1", i, 1'b1, 12'h001);
    step(2'd2, 8'd20); chk_all("run1_over", 12'h005, 12'h005, 1'b0, 1'b1);
    step(2'd0, 8'd20); chk_all("run1_idle", 12'h005, 12'h005, 1'b0, 1'b0);
    enter_run(12'h005);
    for (int i = 1; i <= 5; i++) do_pass("run2", i, 1'b1, 12'h005);
    step(2'd2, 8'd20); chk_all("run2_over", 12'h005, 12'h005, 1'b0, 1'b0);
    step(2'd0, 8'd20);
    enter_run(12'h005);
    for (int i = 1; i <= 6; i++) do_pass("run3", i, 1'b1, 12'h005);
    step(2'd2, 8'd20); chk_all("run3_over", 12'h006, 12'h006, 1'b0, 1'b1);
    step(2'd0, 8'd20); chk_all("run3_idle", 12'h006, 12'h006, 1'b0, 1'b0);

    // Collision: game over on the same cycle as the pass step.
    enter_run(12'h006);
    for (int i = 1; i <= 12; i++) do_pass("coll", i, 1'b1, 12'h006);
    step(2'd1, 8'd4);
    step(2'd2, 8'd3); chk_all("collision", 12'h012, 12'h012, 1'b0, 1'b1);
    step(2'd0, 8'd20);

    // Async reset mid-run with score 7, best 9.
    do_reset();
    enter_run(12'h000);
    for (int i = 1; i <= 9; i++) do_pass("pre9", i, 1'b1, 12'h000);
    step(2'd2, 8'd20);
    step(2'd0, 8'd20);
    enter_run(12'h009);
    for (int i = 1; i <= 7; i++) do_pass("pre7", i, 1'b1, 12'h009);
    step(2'd1, 8'd20);
    chk_all("pre_reset", 12'h007, 12'h009, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all("async_reset", 12'h000, 12'h000, 1'b0, 1'b0);
    bus.scene = 2'd0;
    bus.front_pos = 8'd20;
    #1 rst_n = 1'b1;
    step(2'd0, 8'd4); chk_all("post_rel0", 12'h000, 12'h000, 1'b0, 1'b0);
    step(2'd0, 8'd3); chk_all("post_rel1", 12'h000, 12'h000, 1'b0, 1'b0);

    // Carry and saturation.
    enter_run(12'h000);
    for (int i = 1; i <= 999; i++) do_pass("carry", i, 1'b1, 12'h000);
    do_pass("sat", 999, 1'b0, 12'h000);
    step(2'd1, 8'd2); chk_all("sat_hold", 12'h999, 12'h000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
